i2s_rx: RTL

I2S serial receiver, the capture-side counterpart of the existing i2s transmitter. It deserialises the audio codec ADC stream (AUDIO_DOUT_MFP2) into parallel left/right samples in the 56 MHz system domain. It also derives a hysteresis-filtered 1-bit ear signal from the left channel for tape loading. SCK and LR are generated by the FPGA's own i2s block; this block only observes them and oversamples them with the system clock.

---
 rtl/i2s_rx_pkg.sv | 15 +
 rtl/i2s_sync_edge.sv | 50 +++++
 rtl/i2s_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S capture path: default sample width, default
// ear hysteresis thresholds and the receiver state encoding.
package i2s_rx_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    // Ear comparator thresholds, signed, with LO strictly below HI.
    localparam logic signed [15:0] HI_DEF = 16'sd2048;
    localparam logic signed [15:0] LO_DEF = -16'sd2048;

    typedef logic [0:0] state_t;
    localparam state_t ST_SYNC = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector.
//   clock   : system clock
//   reset   : synchronous active-low reset
//   edge_in : asynchronous strobe whose rising edges are detected (sck)
//   din     : other asynchronous inputs that travel alongside edge_in
//   dout    : din, synchronised and delayed to line up with rise
//   rise    : one-clock pulse per rising edge of edge_in
module i2s_sync_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         edge_in,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         rise
);

    logic [W:0] s1_q, s1_d;
    logic [W:0] s2_q, s2_d;
    logic [W:0] s3_q, s3_d;
    logic       rise_q, rise_d;

    always_comb begin
        s1_d   = {din, edge_in};
        s2_d   = s1_q;
        s3_d   = s2_q;
        rise_d = s2_q[0] & ~s3_q[0];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            rise_q <= rise_d;
        end
    end

    // The edge pulse is registered, so the data is taken one stage later too;
    // both then reflect the pins as sampled on the same clock edge.
    assign dout = s3_q[W:1];
    assign rise = rise_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/lr/d with the system clock, deserialises
// MSB-first slots into left/right samples and drives a hysteresis ear bit
// from the left channel.
//   clock, reset : system clock, synchronous active-low reset
//   sck, lr, d   : I2S bit clock, word select (0 = left), serial data
//   ldata, rdata : last complete left/right sample
//   lstb, rstb   : one-clock pulse when ldata/rdata updates
//   ferr         : one-clock pulse when a slot ends short of WIDTH bits
//   ear          : hysteresis comparator on the left sample
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int unsigned             WIDTH = WIDTH_DEF,
    parameter logic signed [WIDTH-1:0] HI    = HI_DEF,
    parameter logic signed [WIDTH-1:0] LO    = LO_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sck,
    input  logic             lr,
    input  logic             d,
    output logic [WIDTH-1:0] ldata,
    output logic [WIDTH-1:0] rdata,
    output logic             lstb,
    output logic             rstb,
    output logic             ferr,
    output logic             ear
);

    localparam int unsigned    CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);

    logic sck_edge, lr_s, d_s;

    i2s_sync_edge #(
        .W(2)
    ) u_sync (
        .clock  (clock),
        .reset  (reset),
        .edge_in(sck),
        .din    ({lr, d}),
        .dout   ({lr_s, d_s}),
        .rise   (sck_edge)
    );

    state_t             state_q, state_d;
    logic               lr_prev_q, lr_prev_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   ldata_q, ldata_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               lstb_q, lstb_d;
    logic               rstb_q, rstb_d;
    logic               ferr_q, ferr_d;
    logic               ear_q, ear_d;

    logic [WIDTH-1:0]   sh_n;
    logic [CW-1:0]      cnt_n;
    logic               boundary;

    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ldata_d   = ldata_q;
        rdata_d   = rdata_q;
        lstb_d    = 1'b0;
        rstb_d    = 1'b0;
        ferr_d    = 1'b0;
        ear_d     = ear_q;

        // Shift/count for the current bit; bits past WIDTH are dropped.
        sh_n  = sh_q;
        cnt_n = cnt_q;
        if (cnt_q < CNT_FULL) begin
            sh_n  = {sh_q[WIDTH-2:0], d_s};
            cnt_n = cnt_q + CW'(1);
        end

        boundary = (lr_s != lr_prev_q);

        if (sck_edge) begin
            if (state_q == ST_SYNC) begin
                // Wait for a slot boundary; the partial slot in flight is lost.
                if (boundary) begin
                    lr_prev_d = lr_s;
                    cnt_d     = '0;
                    sh_d      = '0;
                    state_d   = ST_RUN;
                end
            end else if (boundary) begin
                // The boundary bit is still the LSB of the slot that is ending.
                if (cnt_n >= CNT_FULL) begin
                    if (!lr_prev_q) begin
                        ldata_d = sh_n;
                        lstb_d  = 1'b1;
                    end else begin
                        rdata_d = sh_n;
                        rstb_d  = 1'b1;
                    end
                end else begin
                    ferr_d = 1'b1;
                end
                cnt_d     = '0;
                sh_d      = '0;
                lr_prev_d = lr_s;
            end else begin
                sh_d  = sh_n;
                cnt_d = cnt_n;
            end
        end

        if (lstb_q) begin
            if ($signed(ldata_q) > HI) begin
                ear_d = 1'b1;
            end else if ($signed(ldata_q) < LO) begin
                ear_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_SYNC;
            lr_prev_q <= 1'b0;
            cnt_q     <= '0;
            sh_q      <= '0;
            ldata_q   <= '0;
            rdata_q   <= '0;
            lstb_q    <= 1'b0;
            rstb_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ear_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ldata_q   <= ldata_d;
            rdata_q   <= rdata_d;
            lstb_q    <= lstb_d;
            rstb_q    <= rstb_d;
            ferr_q    <= ferr_d;
            ear_q     <= ear_d;
        end
    end

    assign ldata = ldata_q;
    assign rdata = rdata_q;
    assign lstb  = lstb_q;
    assign rstb  = rstb_q;
    assign ferr  = ferr_q;
    assign ear   = ear_q;

endmodule
